// File: rtl/stream_run_scheduler.sv
// Host-instruction scheduler: accumulates saturating input charges (SPK) and
// streams them to a network source as RUN frame bursts or a single CLR frame.
module stream_run_scheduler #(
  parameter int NUM_INP      = 1,
  parameter int CHARGE_WIDTH = 8,
  parameter int RUN_WIDTH    = 16
) (
  input  logic                              clk,
  input  logic                              arstn,
  input  logic                              instr_valid,
  output logic                              instr_ready,
  input  logic [1:0]                        instr_opc,
  input  logic [RUN_WIDTH-1:0]              instr_run,
  input  logic [NUM_INP*CHARGE_WIDTH-1:0]   instr_inp,
  output logic                              src_valid,
  input  logic                              src_ready,
  output logic [NUM_INP*CHARGE_WIDTH:0]     src,
  output logic                              busy,
  output logic                              run_done
);

  localparam int CW = CHARGE_WIDTH;
  localparam int DW = NUM_INP * CHARGE_WIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_CLR} state_t;

  state_t                r_state, w_state_nxt;
  logic signed [CW-1:0]  r_pending [NUM_INP];
  logic signed [CW-1:0]  w_pending_sat [NUM_INP];
  logic signed [CW:0]    w_sum [NUM_INP];
  logic [RUN_WIDTH-1:0]  r_remaining;
  logic                  r_first;
  logic                  r_src_valid;
  logic                  r_run_done;

  logic w_accept, w_spk, w_run, w_run0, w_clr, w_fire, w_last, w_clr_done;

  assign w_accept   = instr_valid && (r_state == ST_IDLE);
  assign w_spk      = w_accept && (instr_opc == 2'd0);
  assign w_run      = w_accept && (instr_opc == 2'd1) && (instr_run != '0);
  assign w_run0     = w_accept && (instr_opc == 2'd1) && (instr_run == '0);
  assign w_clr      = w_accept && (instr_opc == 2'd2);
  assign w_fire     = r_src_valid && src_ready;
  assign w_last     = w_fire && (r_state == ST_RUN) && (r_remaining == RUN_WIDTH'(1));
  assign w_clr_done = w_fire && (r_state == ST_CLR);

  assign src_valid = r_src_valid;
  assign run_done  = r_run_done;

  // Sign-extend by one bit; overflow shows as disagreement of the top two bits.
  always_comb begin
    for (int unsigned i = 0; i < NUM_INP; i++) begin
      w_sum[i] = {r_pending[i][CW-1], r_pending[i]} +
                 {instr_inp[DW-1-i*CW], instr_inp[DW-1-i*CW -: CW]};
      if (w_sum[i][CW] != w_sum[i][CW-1])
        w_pending_sat[i] = w_sum[i][CW] ? {1'b1, {(CW-1){1'b0}}} : {1'b0, {(CW-1){1'b1}}};
      else
        w_pending_sat[i] = w_sum[i][CW-1:0];
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_run)      w_state_nxt = ST_RUN;
        else if (w_clr) w_state_nxt = ST_CLR;
      end
      ST_RUN:  if (w_last)     w_state_nxt = ST_IDLE;
      ST_CLR:  if (w_clr_done) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (r_state == ST_IDLE);
    busy        = (r_state != ST_IDLE);
    src         = '0;
    if (r_state == ST_CLR) begin
      src[DW] = 1'b1;
    end else if (r_state == ST_RUN && r_first) begin
      for (int unsigned i = 0; i < NUM_INP; i++)
        src[DW-1-i*CW -: CW] = r_pending[i];
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_src_valid <= 1'b0;
      r_run_done  <= 1'b0;
      r_remaining <= '0;
      r_first     <= 1'b0;
      for (int unsigned i = 0; i < NUM_INP; i++) r_pending[i] <= '0;
    end else begin
      r_run_done <= w_run0 || w_last || w_clr_done;

      if (w_run || w_clr)            r_src_valid <= 1'b1;
      else if (w_last || w_clr_done) r_src_valid <= 1'b0;

      if (w_run) begin
        r_remaining <= instr_run;
        r_first     <= 1'b1;
      end else if (w_fire && r_state == ST_RUN) begin
        r_remaining <= r_remaining - RUN_WIDTH'(1);
        r_first     <= 1'b0;
      end

      for (int unsigned i = 0; i < NUM_INP; i++) begin
        if (w_spk)
          r_pending[i] <= w_pending_sat[i];
        else if ((w_fire && r_state == ST_RUN && r_first) || w_clr_done)
          r_pending[i] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_stream_run_scheduler.sv
// Bench for stream_run_scheduler with NUM_INP=2, CHARGE_WIDTH=8, RUN_WIDTH=4.
module tb_stream_run_scheduler;

  localparam int NI = 2;
  localparam int CW = 8;
  localparam int RW = 4;
  localparam logic [1:0] OP_SPK = 2'd0, OP_RUN = 2'd1, OP_CLR = 2'd2, OP_NOP = 2'd3;

  logic            clk = 1'b0;
  logic            arstn = 1'b0;
  logic            instr_valid = 1'b0;
  logic            instr_ready;
  logic [1:0]      instr_opc = OP_NOP;
  logic [RW-1:0]   instr_run = '0;
  logic [NI*CW-1:0] instr_inp = '0;
  logic            src_valid;
  logic            src_ready = 1'b1;
  logic [NI*CW:0]  src;
  logic            busy;
  logic            run_done;

  int total = 0;
  int bad   = 0;
  int stall_pct = 0;
  int p0 = 0, p1 = 0;

  stream_run_scheduler #(.NUM_INP(NI), .CHARGE_WIDTH(CW), .RUN_WIDTH(RW)) dut (
    .clk(clk), .arstn(arstn), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opc(instr_opc), .instr_run(instr_run), .instr_inp(instr_inp),
    .src_valid(src_valid), .src_ready(src_ready), .src(src), .busy(busy), .run_done(run_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] opc;
    int run, a, b;
    int e_op, e_c0, e_c1, e_n, stall;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat8(input int v);
    return (v > 127) ? 127 : ((v < -128) ? -128 : v);
  endfunction

  function automatic logic [16:0] frame(input int op, input int c0, input int c1);
    logic [31:0] x0, x1;
    x0 = c0; x1 = c1;
    return {op[0], x0[7:0], x1[7:0]};
  endfunction

  // Called at a negedge; returns at a negedge with the scheduler idle again.
  task automatic issue(input logic [1:0] opc, input int run, input int a, input int b,
                       input int e_op, input int e_c0, input int e_c1, input int e_n,
                       input int stall_n);
    int guard, k, forced;
    logic [31:0] xa, xb;
    logic [16:0] expf;
    guard = 0;
    while (!instr_ready && guard < 50) begin @(negedge clk); guard++; end
    chk("ready_wait", instr_ready, 1);
    xa = a; xb = b;
    instr_opc = opc; instr_run = RW'(run); instr_inp = {xa[7:0], xb[7:0]};
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    if (opc == OP_SPK || opc == OP_NOP) begin
      chk("idle_valid", src_valid, 0);
      chk("idle_done", run_done, 0);
      chk("idle_ready", instr_ready, 1);
    end else if (e_n == 0) begin
      chk("run0_valid", src_valid, 0);
      chk("run0_done", run_done, 1);
      @(negedge clk);
      chk("run0_done_end", run_done, 0);
    end else begin
      k = 0; forced = 0; guard = 0;
      while (k < e_n && guard < 500) begin
        expf = (k == 0) ? frame(e_op, e_c0, e_c1) : frame(e_op, 0, 0);
        chk("frame_valid", src_valid, 1);
        chk("frame_data", src, expf);
        chk("busy_ready", instr_ready, 0);
        chk("frame_nodone", run_done, 0);
        if (forced < stall_n || int'($urandom_range(0, 99)) < stall_pct) begin
          src_ready = 1'b0; forced++;
        end else begin
          src_ready = 1'b1; k++;
        end
        @(negedge clk); guard++;
      end
      src_ready = 1'b1;
      chk("frame_count", k, e_n);
      chk("end_valid", src_valid, 0);
      chk("end_done", run_done, 1);
      chk("end_busy", busy, 0);
      @(negedge clk);
      chk("end_done_off", run_done, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{OP_SPK, 0,    5,   -3, 0, 0,    0,    0,  0};
    vt[1]  = '{OP_SPK, 0,  126, -127, 0, 0,    0,    0,  0};
    vt[2]  = '{OP_RUN, 3,    0,    0, 0, 127, -128,  3,  0};
    vt[3]  = '{OP_SPK, 0,   10,    0, 0, 0,    0,    0,  0};
    vt[4]  = '{OP_RUN, 0,    0,    0, 0, 0,    0,    0,  0};
    vt[5]  = '{OP_RUN, 1,    0,    0, 0, 10,   0,    1,  0};
    vt[6]  = '{OP_SPK, 0,    4,    4, 0, 0,    0,    0,  0};
    vt[7]  = '{OP_CLR, 0,    0,    0, 1, 0,    0,    1,  0};
    vt[8]  = '{OP_RUN, 1,    0,    0, 0, 0,    0,    1,  0};
    vt[9]  = '{OP_NOP, 0,    5,    5, 0, 0,    0,    0,  0};
    vt[10] = '{OP_RUN, 15,   0,    0, 0, 0,    0,    15, 0};
    vt[11] = '{OP_SPK, 0,    3,   -2, 0, 0,    0,    0,  0};
    vt[12] = '{OP_RUN, 2,    0,    0, 0, 3,   -2,    2,  5};
    vt[13] = '{OP_SPK, 0, -100,  100, 0, 0,    0,    0,  0};
    vt[14] = '{OP_SPK, 0, -100,  100, 0, 0,    0,    0,  0};
    vt[15] = '{OP_RUN, 1,    0,    0, 0, -128, 127,  1,  0};

    #3;
    chk("rst_src", src, 0);
    chk("rst_valid", src_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", instr_ready, 1);
    chk("rst_done", run_done, 0);
    repeat (2) @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    chk("post_rst_src", src, 0);
    chk("post_rst_valid", src_valid, 0);

    for (int i = 0; i < 16; i++)
      issue(vt[i].opc, vt[i].run, vt[i].a, vt[i].b, vt[i].e_op, vt[i].e_c0, vt[i].e_c1,
            vt[i].e_n, vt[i].stall);

    // SPK held by the host while a RUN is in progress.
    issue(OP_SPK, 0, 7, -7, 0, 0, 0, 0, 0);
    instr_opc = OP_RUN; instr_run = RW'(2); instr_valid = 1'b1;
    @(negedge clk);
    instr_opc = OP_SPK; instr_inp = {8'd20, 8'd20};
    src_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_src", src, frame(0, 7, -7));
      chk("hold_ready", instr_ready, 0);
      @(negedge clk);
    end
    src_ready = 1'b1;
    chk("hold_f0", src, frame(0, 7, -7));
    @(negedge clk);
    chk("hold_f1", src, frame(0, 0, 0));
    chk("hold_f1_ready", instr_ready, 0);
    @(negedge clk);
    chk("hold_done", run_done, 1);
    chk("hold_idle", instr_ready, 1);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("hold_spk_novalid", src_valid, 0);
    issue(OP_RUN, 1, 0, 0, 0, 20, 20, 1, 0);

    // Reset in the middle of a RUN burst.
    issue(OP_SPK, 0, 9, 9, 0, 0, 0, 0, 0);
    instr_opc = OP_RUN; instr_run = RW'(4); instr_valid = 1'b1; src_ready = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("mid_f0", src, frame(0, 9, 9));
    @(negedge clk);
    chk("mid_f1", src, frame(0, 0, 0));
    @(negedge clk);
    chk("mid_f2_valid", src_valid, 1);
    arstn = 1'b0;
    #1;
    chk("mid_rst_valid", src_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_src", src, 0);
    @(negedge clk);
    arstn = 1'b1;
    #1;
    chk("mid_rel_ready", instr_ready, 1);
    chk("mid_rel_done", run_done, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_no_done", run_done, 0);
      chk("mid_no_valid", src_valid, 0);
    end
    issue(OP_RUN, 1, 0, 0, 0, 0, 0, 1, 0);

    // Randomized phase against the instruction-level model.
    p0 = 0; p1 = 0;
    stall_pct = 25;
    for (int n = 0; n < 80; n++) begin
      logic [1:0] opc;
      int run, a, b;
      opc = 2'($urandom_range(0, 3));
      run = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 4));
      a = int'($urandom_range(0, 255)) - 128;
      b = int'($urandom_range(0, 255)) - 128;
      case (opc)
        OP_SPK: begin
          issue(opc, run, a, b, 0, 0, 0, 0, 0);
          p0 = sat8(p0 + a); p1 = sat8(p1 + b);
        end
        OP_RUN: begin
          issue(opc, run, a, b, 0, p0, p1, run, 0);
          if (run != 0) begin p0 = 0; p1 = 0; end
        end
        OP_CLR: begin
          issue(opc, run, a, b, 1, 0, 0, 1, 0);
          p0 = 0; p1 = 0;
        end
        default: issue(opc, run, a, b, 0, 0, 0, 0, 0);
      endcase
    end
    issue(OP_RUN, 1, 0, 0, 0, p0, p1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
